// File: rtl/card_pkg.sv
// rtl/card_pkg.sv - shared card widths, round-sequencer states and winner encodings.
package card_pkg;

   localparam int COLOR_W = 2;
   localparam int NUM_W   = 3;
   localparam int PTS_W   = 4;
   localparam int RND_W   = 5;
   localparam int CNT_W   = 3;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ARB  = 3'd1,
      DEAL = 3'd2,
      POST = 3'd3,
      DONE = 3'd4
   } state_e;

   localparam logic [1:0] W_NONE = 2'b00;
   localparam logic [1:0] W_P1   = 2'b01;
   localparam logic [1:0] W_P2   = 2'b10;
   localparam logic [1:0] W_TIE  = 2'b11;

endpackage

// File: rtl/deal_ctrl_if.sv
// rtl/deal_ctrl_if.sv - draw request / dealt card / score bundle between turn logic and deal_ctrl.
interface deal_ctrl_if
   import card_pkg::*;
#(
   parameter int SCORE_W = 8
);
   logic                 start;
   logic                 req1;
   logic                 req2;
   logic [RND_W-1:0]     rnd;
   logic                 grant1;
   logic                 grant2;
   logic                 card_vld;
   logic                 card_who;
   logic [COLOR_W-1:0]   card_color;
   logic [NUM_W-1:0]     card_num;
   logic [CNT_W-1:0]     cnt1;
   logic [CNT_W-1:0]     cnt2;
   logic [SCORE_W-1:0]   score1;
   logic [SCORE_W-1:0]   score2;
   logic                 round_done;
   logic [1:0]           winner;

   modport master (
      output start, req1, req2, rnd,
      input  grant1, grant2, card_vld, card_who, card_color, card_num,
             cnt1, cnt2, score1, score2, round_done, winner
   );

   modport slave (
      input  start, req1, req2, rnd,
      output grant1, grant2, card_vld, card_who, card_color, card_num,
             cnt1, cnt2, score1, score2, round_done, winner
   );

endinterface

// File: rtl/card_decode.sv
// rtl/card_decode.sv - combinational LFSR value to color/number/points decode.
module card_decode
   import card_pkg::*;
(
   input  logic [RND_W-1:0]   rnd_i,
   output logic [COLOR_W-1:0] color_o,
   output logic [NUM_W-1:0]   num_o,
   output logic [PTS_W-1:0]   pts_o
);

   logic [COLOR_W-1:0] color;
   logic [NUM_W-1:0]   num;
   logic [PTS_W-1:0]   color_ext;
   logic [PTS_W-1:0]   num_plus1;

   // Color is (rnd[4:3] mod 3) + 1, so code 3 folds back onto color 1.
   always_comb begin
      color = 2'd1;
      case (rnd_i[4:3])
         2'd0:    color = 2'd1;
         2'd1:    color = 2'd2;
         2'd2:    color = 2'd3;
         default: color = 2'd1;
      endcase
   end

   always_comb begin
      num = rnd_i[2:0];
      if (rnd_i[2:0] >= 3'd5) begin
         num = rnd_i[2:0] - 3'd5;
      end
   end

   assign color_ext = {2'b00, color};
   assign num_plus1 = {1'b0, num} + 4'd1;

   assign color_o = color;
   assign num_o   = num;
   assign pts_o   = color_ext * num_plus1;

endmodule

// File: rtl/deal_ctrl.sv
// rtl/deal_ctrl.sv - two-player round sequencer: arbiter, deal FSM, hand counts and scores.
// Optional DEAL_CTRL_SCORE_SAT_EN makes score accumulation saturate instead of wrap.
module deal_ctrl
   import card_pkg::*;
#(
   parameter int HAND_MAX = 5,
   parameter int SCORE_W  = 8
)(
   input  logic         clk,
   input  logic         rst,
   deal_ctrl_if.slave   bus
);

   localparam logic [CNT_W-1:0] HAND_FULL = CNT_W'(HAND_MAX);

   state_e               state_q, state_d;
   logic                 token_q;
   logic                 who_q, who_d;
   logic [CNT_W-1:0]     cnt1_q, cnt2_q;
   logic [SCORE_W-1:0]   score1_q, score2_q;
   logic                 card_who_q;
   logic [COLOR_W-1:0]   color_q;
   logic [NUM_W-1:0]     num_q;

   logic                 el1, el2;
   logic [COLOR_W-1:0]   dec_color;
   logic [NUM_W-1:0]     dec_num;
   logic [PTS_W-1:0]     dec_pts;

   card_decode u_decode (
      .rnd_i   (bus.rnd),
      .color_o (dec_color),
      .num_o   (dec_num),
      .pts_o   (dec_pts)
   );

   function automatic logic [SCORE_W-1:0] score_add(input logic [SCORE_W-1:0] a,
                                                    input logic [PTS_W-1:0]   p);
`ifdef DEAL_CTRL_SCORE_SAT_EN
      logic [SCORE_W:0] sum;
      sum = {1'b0, a} + (SCORE_W+1)'(p);
      return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
`else
      return a + SCORE_W'(p);
`endif
   endfunction

   assign el1 = bus.req1 && (cnt1_q < HAND_FULL);
   assign el2 = bus.req2 && (cnt2_q < HAND_FULL);

   // Token only breaks ties; a lone eligible player wins outright.
   assign who_d = (el1 && el2) ? token_q : !el1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (bus.start) begin
         state_d = ARB;
      end else begin
         case (state_q)
            IDLE: state_d = IDLE;
            ARB:  if (el1 || el2) state_d = DEAL;
            DEAL: state_d = POST;
            POST: state_d = (cnt1_q == HAND_FULL && cnt2_q == HAND_FULL) ? DONE : ARB;
            DONE: state_d = DONE;
            default: state_d = IDLE;
         endcase
      end
   end

   // The card is committed on leaving DEAL so POST already shows updated count/score;
   // start in that cycle wins and the card is simply never booked.
   always_ff @(posedge clk) begin
      if (rst) begin
         token_q    <= 1'b0;
         who_q      <= 1'b0;
         cnt1_q     <= '0;
         cnt2_q     <= '0;
         score1_q   <= '0;
         score2_q   <= '0;
         card_who_q <= 1'b0;
         color_q    <= '0;
         num_q      <= '0;
      end else if (bus.start) begin
         cnt1_q   <= '0;
         cnt2_q   <= '0;
         score1_q <= '0;
         score2_q <= '0;
      end else begin
         if (state_q == ARB && (el1 || el2)) begin
            who_q <= who_d;
         end
         if (state_q == DEAL) begin
            card_who_q <= who_q;
            color_q    <= dec_color;
            num_q      <= dec_num;
            token_q    <= !who_q;
            if (who_q) begin
               cnt2_q   <= cnt2_q + 3'd1;
               score2_q <= score_add(score2_q, dec_pts);
            end else begin
               cnt1_q   <= cnt1_q + 3'd1;
               score1_q <= score_add(score1_q, dec_pts);
            end
         end
      end
   end

   always_comb begin
      bus.grant1     = (state_q == DEAL) && !who_q;
      bus.grant2     = (state_q == DEAL) && who_q;
      bus.card_vld   = (state_q == POST);
      bus.round_done = (state_q == DONE);
      bus.winner     = W_NONE;
      if (state_q == DONE) begin
         if (score1_q > score2_q) begin
            bus.winner = W_P1;
         end else if (score2_q > score1_q) begin
            bus.winner = W_P2;
         end else begin
            bus.winner = W_TIE;
         end
      end
   end

   assign bus.card_who   = card_who_q;
   assign bus.card_color = color_q;
   assign bus.card_num   = num_q;
   assign bus.cnt1       = cnt1_q;
   assign bus.cnt2       = cnt2_q;
   assign bus.score1     = score1_q;
   assign bus.score2     = score2_q;

endmodule

// File: tb/tb_deal_ctrl.sv
// tb/tb_deal_ctrl.sv - directed self-checking bench for deal_ctrl (main instance plus 4-bit score instance).
module tb_deal_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   n_pass = 0;
   int   n_chk  = 0;

   always #5 clk = ~clk;

   deal_ctrl_if #(.SCORE_W(8)) bus_a ();
   deal_ctrl_if #(.SCORE_W(4)) bus_b ();

   deal_ctrl #(.HAND_MAX(5), .SCORE_W(8)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   deal_ctrl #(.HAND_MAX(2), .SCORE_W(4)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts in ARB; runs ARB->DEAL->POST->next and checks grant and strobe.
   task automatic do_deal(input logic who, input string tag);
      tick();
      chk({tag, " grant1"}, bus_a.grant1, !who);
      chk({tag, " grant2"}, bus_a.grant2, who);
      tick();
      chk({tag, " card_vld"}, bus_a.card_vld, 1);
      chk({tag, " card_who"}, bus_a.card_who, who);
      tick();
   endtask

   initial begin
      logic [3:0] exp_b;
      rst = 1'b1;
      bus_a.start = 0; bus_a.req1 = 0; bus_a.req2 = 0; bus_a.rnd = '0;
      bus_b.start = 0; bus_b.req1 = 0; bus_b.req2 = 0; bus_b.rnd = '0;
      tick();
      tick();

      chk("rst grant1", bus_a.grant1, 0);
      chk("rst grant2", bus_a.grant2, 0);
      chk("rst card_vld", bus_a.card_vld, 0);
      chk("rst round_done", bus_a.round_done, 0);
      chk("rst card_who", bus_a.card_who, 0);
      chk("rst card_color", bus_a.card_color, 0);
      chk("rst card_num", bus_a.card_num, 0);
      chk("rst cnt1", bus_a.cnt1, 0);
      chk("rst cnt2", bus_a.cnt2, 0);
      chk("rst score1", bus_a.score1, 0);
      chk("rst score2", bus_a.score2, 0);
      chk("rst winner", bus_a.winner, 0);
      chk("rst b score1", bus_b.score1, 0);
      rst = 1'b0;

      // IDLE ignores requests
      bus_a.req1 = 1;
      tick();
      chk("idle grant1 a", bus_a.grant1, 0);
      tick();
      chk("idle grant1 b", bus_a.grant1, 0);

      // first card: 11100 -> color 1, num 4, 5 points
      bus_a.rnd = 5'b11100;
      bus_a.start = 1;
      tick();
      bus_a.start = 0;
      chk("t1 arb grant1", bus_a.grant1, 0);
      tick();
      chk("t1 deal grant1", bus_a.grant1, 1);
      chk("t1 deal card_vld", bus_a.card_vld, 0);
      bus_a.req1 = 0;
      tick();
      chk("t1 post card_vld", bus_a.card_vld, 1);
      chk("t1 card_who", bus_a.card_who, 0);
      chk("t1 color", bus_a.card_color, 1);
      chk("t1 num", bus_a.card_num, 4);
      chk("t1 score1", bus_a.score1, 5);
      chk("t1 cnt1", bus_a.cnt1, 1);
      tick();
      chk("t1 after card_vld", bus_a.card_vld, 0);

      // both request; token now at P2; 01011 -> color 2, num 3, 8 points
      bus_a.req1 = 1; bus_a.req2 = 1; bus_a.rnd = 5'b01011;
      do_deal(1, "alt0");
      chk("alt0 color", bus_a.card_color, 2);
      chk("alt0 num", bus_a.card_num, 3);
      chk("alt0 score2", bus_a.score2, 8);
      chk("alt0 cnt2", bus_a.cnt2, 1);
      do_deal(0, "alt1");
      chk("alt1 score1", bus_a.score1, 13);
      do_deal(1, "alt2");
      chk("alt2 score2", bus_a.score2, 16);

      // only P2 until its hand is full
      bus_a.req1 = 0;
      for (int i = 0; i < 3; i++) do_deal(1, "p2only");
      chk("p2 full cnt2", bus_a.cnt2, 5);
      chk("p2 full score2", bus_a.score2, 40);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("p2 full no grant2", bus_a.grant2, 0);
         chk("p2 full no vld", bus_a.card_vld, 0);
      end

      // P1 fills its hand while req2 stays high but ineligible
      bus_a.req1 = 1;
      do_deal(0, "p1fill0");
      do_deal(0, "p1fill1");
      chk("p1fill round_done low", bus_a.round_done, 0);
      chk("p1fill winner none", bus_a.winner, 0);
      do_deal(0, "p1fill2");
      chk("end cnt1", bus_a.cnt1, 5);
      chk("end score1", bus_a.score1, 37);
      chk("end round_done", bus_a.round_done, 1);
      chk("end winner p2", bus_a.winner, 2'b10);
      tick();
      chk("done hold round_done", bus_a.round_done, 1);
      chk("done hold winner", bus_a.winner, 2'b10);
      chk("done no grant1", bus_a.grant1, 0);

      // tie round: 10111 -> color 3, num 2, 9 points each
      bus_a.rnd = 5'b10111;
      bus_a.start = 1;
      tick();
      bus_a.start = 0;
      chk("tie clr cnt1", bus_a.cnt1, 0);
      chk("tie clr score1", bus_a.score1, 0);
      chk("tie clr score2", bus_a.score2, 0);
      chk("tie clr round_done", bus_a.round_done, 0);
      chk("tie clr winner", bus_a.winner, 0);
      for (int i = 0; i < 10; i++) do_deal((i % 2) == 0, "tie");
      chk("tie score1", bus_a.score1, 45);
      chk("tie score2", bus_a.score2, 45);
      chk("tie round_done", bus_a.round_done, 1);
      chk("tie winner", bus_a.winner, 2'b11);
      chk("tie color", bus_a.card_color, 3);
      chk("tie num", bus_a.card_num, 2);

      // abort in DEAL drops the card
      bus_a.req1 = 1; bus_a.req2 = 0;
      bus_a.start = 1;
      tick();
      bus_a.start = 0;
      tick();
      chk("abort deal grant1", bus_a.grant1, 1);
      bus_a.start = 1;
      tick();
      bus_a.start = 0;
      chk("abort card_vld", bus_a.card_vld, 0);
      chk("abort cnt1", bus_a.cnt1, 0);
      chk("abort score1", bus_a.score1, 0);
      chk("abort arb grant1", bus_a.grant1, 0);
      tick();
      chk("abort redeal grant1", bus_a.grant1, 1);
      tick();
      chk("abort redeal vld", bus_a.card_vld, 1);
      chk("abort redeal cnt1", bus_a.cnt1, 1);
      chk("abort redeal score1", bus_a.score1, 9);
      bus_a.req1 = 0;

      // 4-bit score: two 9-point cards
`ifdef DEAL_CTRL_SCORE_SAT_EN
      exp_b = 4'd15;
`else
      exp_b = 4'd2;
`endif
      bus_b.rnd = 5'b10111; bus_b.req1 = 1; bus_b.start = 1;
      tick();
      bus_b.start = 0;
      tick();
      tick();
      chk("b first score1", bus_b.score1, 9);
      tick();
      tick();
      tick();
      chk("b second vld", bus_b.card_vld, 1);
      chk("b second score1", bus_b.score1, exp_b);
      chk("b second cnt1", bus_b.cnt1, 2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
